// File: rtl/instr_mem_responder_if.sv
// -----------------------------------------------------------------------------
// instr_mem_responder_if
//
// Core instruction-fetch bus: a request/grant handshake followed by an in-order
// response phase with no response backpressure.
//
// Signals
//   instr_req     requester -> responder  fetch request valid
//   instr_addr    requester -> responder  fetch byte address (bits [1:0] ignored)
//   instr_gnt     responder -> requester  request accepted this cycle
//   instr_rvalid  responder -> requester  response valid (one cycle per grant)
//   instr_rdata   responder -> requester  response word
//   instr_err     responder -> requester  response error (address out of range)
//
// Modports
//   master  prefetch / requester side
//   slave   memory / responder side
// -----------------------------------------------------------------------------
interface instr_mem_responder_if;

    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;

    modport master (
        output instr_req,
        output instr_addr,
        input  instr_gnt,
        input  instr_rvalid,
        input  instr_rdata,
        input  instr_err
    );

    modport slave (
        input  instr_req,
        input  instr_addr,
        output instr_gnt,
        output instr_rvalid,
        output instr_rdata,
        output instr_err
    );

endinterface : instr_mem_responder_if

// File: rtl/instr_mem_responder.sv
// -----------------------------------------------------------------------------
// instr_mem_responder
//
// Responder end of the instruction-fetch bus. Fetches are answered from a
// word-organised on-chip memory after a fixed number of cycles, strictly in
// grant order, with a cap on granted-but-unanswered requests. A write port
// preloads the program image and a stall input injects grant backpressure.
//
// Parameters
//   MemWords        number of 32-bit words (power of two, >= 16)
//   BaseAddr        byte address of word 0 (aligned to 4*MemWords)
//   Latency         cycles from grant to rvalid (1..4)
//   MaxOutstanding  max granted-but-unanswered requests (1..Latency+1)
//
// Ports
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   bus        fetch bus, slave side (req/addr in, gnt/rvalid/rdata/err out)
//   stall_i    forces the grant low while high
//   wr_en_i    preload write strobe
//   wr_addr_i  preload byte address (bits [1:0] ignored, out of range dropped)
//   wr_data_i  preload data
// -----------------------------------------------------------------------------
module instr_mem_responder #(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned Latency        = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    instr_mem_responder_if.slave        bus,
    input  logic                        stall_i,
    input  logic                        wr_en_i,
    input  logic [31:0]                 wr_addr_i,
    input  logic [31:0]                 wr_data_i
);

    localparam int unsigned IdxW = $clog2(MemWords);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    // Range bounds are kept 33 bits wide so a window ending at 4 GiB does not
    // wrap the upper bound to zero.
    localparam logic [32:0] AddrLo = {1'b0, BaseAddr};
    localparam logic [32:0] AddrHi = AddrLo + (33'(MemWords) << 2);

    // One in-flight fetch: the word to read, or an error marker.
    typedef struct packed {
        logic            valid;
        logic [IdxW-1:0] idx;
        logic            err;
    } fetch_t;

    function automatic logic addr_in_range(input logic [31:0] addr);
        logic [32:0] addr_ext;
        addr_ext = {1'b0, addr};
        return (addr_ext >= AddrLo) && (addr_ext < AddrHi);
    endfunction

    function automatic logic [IdxW-1:0] addr_to_idx(input logic [31:0] addr);
        return IdxW'((addr - BaseAddr) >> 2);
    endfunction

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [31:0]     mem_q [MemWords];
    logic            wr_ok;
    logic [IdxW-1:0] wr_idx;

    assign wr_ok  = wr_en_i && addr_in_range(wr_addr_i);
    assign wr_idx = addr_to_idx(wr_addr_i);

    // NOTE: the memory array has no reset so it maps onto RAM; the program
    // image survives a core reset.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wr_idx] <= wr_data_i;
        end
    end

    // -------------------------------------------------------------------------
    // Grant and outstanding-request accounting
    // -------------------------------------------------------------------------
    logic            gnt;
    logic            accept;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_live;
    logic            rvalid_q, rvalid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    // A response leaving this cycle already frees its slot, so a new request
    // can be granted in the same cycle the oldest one is answered.
    assign cnt_live = cnt_q - CntW'(rvalid_q);
    assign gnt      = bus.instr_req & ~stall_i & ~rst_i
                    & (cnt_live < CntW'(MaxOutstanding));
    assign accept   = bus.instr_req & gnt;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({accept, rvalid_q})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Latency pipeline
    //
    // The output register is the final stage, so only Latency-1 intermediate
    // stages exist. last_fetch is the entry crossing into the output register
    // on the coming edge; its memory read happens on that same edge.
    // -------------------------------------------------------------------------
    fetch_t new_fetch;
    fetch_t last_fetch;

    always_comb begin
        new_fetch       = '0;
        new_fetch.valid = accept;
        new_fetch.idx   = addr_to_idx(bus.instr_addr);
        new_fetch.err   = ~addr_in_range(bus.instr_addr);
    end

    if (Latency > 1) begin : g_pipe
        fetch_t pipe_q [Latency-1];
        fetch_t pipe_d [Latency-1];

        always_comb begin
            pipe_d[0] = new_fetch;
            for (int i = 1; i < int'(Latency) - 1; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end

        // NOTE: sequential state uses non-blocking assignments only, so every
        // stage samples the value its neighbour held before the edge.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                pipe_q <= '{default: '0};
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign last_fetch = pipe_q[Latency-2];
    end else begin : g_no_pipe
        assign last_fetch = new_fetch;
    end

    // -------------------------------------------------------------------------
    // Response register
    //
    // mem_q is read before this edge's write lands, so a same-cycle write to
    // the word being sampled returns the old data; a write on any earlier edge
    // is already visible.
    // -------------------------------------------------------------------------
    always_comb begin
        rvalid_d = last_fetch.valid;
        rdata_d  = rdata_q;
        err_d    = err_q;
        if (last_fetch.valid) begin
            if (last_fetch.err) begin
                rdata_d = '0;
                err_d   = 1'b1;
            end else begin
                rdata_d = mem_q[last_fetch.idx];
                err_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign bus.instr_gnt    = gnt;
    assign bus.instr_rvalid = rvalid_q;
    assign bus.instr_rdata  = rdata_q;
    assign bus.instr_err    = err_q;

    // -------------------------------------------------------------------------
    // Simulation checks on the outstanding counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (cnt_q <= CntW'(MaxOutstanding))
                else $error("outstanding count %0d above limit %0d", cnt_q, MaxOutstanding);
            assert (!(rvalid_q && (cnt_q == '0)))
                else $error("response issued with no outstanding request");
        end
    end

endmodule : instr_mem_responder

// File: tb/tb_instr_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_responder
//
// Four responders with different latency / outstanding limits run side by side
// on one clock:
//   0: Latency 1, MaxOutstanding 2  (single fetch, error, stall, collision)
//   1: Latency 2, MaxOutstanding 2  (back-to-back, in-flight write)
//   2: Latency 3, MaxOutstanding 1  (outstanding limit)
//   3: Latency 3, MaxOutstanding 2  (reset while requests are in flight)
// A scoreboard per instance records each grant with its due cycle; the data is
// taken from a reference memory on the cycle the read samples, and compared
// when rvalid appears. The grant is checked every cycle against the
// outstanding-limit rule.
// -----------------------------------------------------------------------------
module tb_instr_mem_responder;

    localparam int LAT  [4] = '{1, 2, 3, 3};
    localparam int MAXO [4] = '{2, 2, 1, 2};

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [9:0]  idx;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    logic        rst_s     [4];
    logic        req_s     [4];
    logic [31:0] addr_s    [4];
    logic        stall_s   [4];
    logic        wr_en_s   [4];
    logic [31:0] wr_addr_s [4];
    logic [31:0] wr_data_s [4];
    logic        gnt_w     [4];
    logic        rvalid_w  [4];
    logic [31:0] rdata_w   [4];
    logic        err_w     [4];

    logic [31:0] mdl [4][1024];
    exp_t        sb  [4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_mem_responder_if a_if ();
    instr_mem_responder_if b_if ();
    instr_mem_responder_if c_if ();
    instr_mem_responder_if d_if ();

    assign a_if.instr_req  = req_s[0];
    assign a_if.instr_addr = addr_s[0];
    assign gnt_w[0]        = a_if.instr_gnt;
    assign rvalid_w[0]     = a_if.instr_rvalid;
    assign rdata_w[0]      = a_if.instr_rdata;
    assign err_w[0]        = a_if.instr_err;

    assign b_if.instr_req  = req_s[1];
    assign b_if.instr_addr = addr_s[1];
    assign gnt_w[1]        = b_if.instr_gnt;
    assign rvalid_w[1]     = b_if.instr_rvalid;
    assign rdata_w[1]      = b_if.instr_rdata;
    assign err_w[1]        = b_if.instr_err;

    assign c_if.instr_req  = req_s[2];
    assign c_if.instr_addr = addr_s[2];
    assign gnt_w[2]        = c_if.instr_gnt;
    assign rvalid_w[2]     = c_if.instr_rvalid;
    assign rdata_w[2]      = c_if.instr_rdata;
    assign err_w[2]        = c_if.instr_err;

    assign d_if.instr_req  = req_s[3];
    assign d_if.instr_addr = addr_s[3];
    assign gnt_w[3]        = d_if.instr_gnt;
    assign rvalid_w[3]     = d_if.instr_rvalid;
    assign rdata_w[3]      = d_if.instr_rdata;
    assign err_w[3]        = d_if.instr_err;

    instr_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .Latency(1), .MaxOutstanding(2)) dut_a (
        .clk_i(clk), .rst_i(rst_s[0]), .bus(a_if), .stall_i(stall_s[0]),
        .wr_en_i(wr_en_s[0]), .wr_addr_i(wr_addr_s[0]), .wr_data_i(wr_data_s[0]));
    instr_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .Latency(2), .MaxOutstanding(2)) dut_b (
        .clk_i(clk), .rst_i(rst_s[1]), .bus(b_if), .stall_i(stall_s[1]),
        .wr_en_i(wr_en_s[1]), .wr_addr_i(wr_addr_s[1]), .wr_data_i(wr_data_s[1]));
    instr_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .Latency(3), .MaxOutstanding(1)) dut_c (
        .clk_i(clk), .rst_i(rst_s[2]), .bus(c_if), .stall_i(stall_s[2]),
        .wr_en_i(wr_en_s[2]), .wr_addr_i(wr_addr_s[2]), .wr_data_i(wr_data_s[2]));
    instr_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .Latency(3), .MaxOutstanding(2)) dut_d (
        .clk_i(clk), .rst_i(rst_s[3]), .bus(d_if), .stall_i(stall_s[3]),
        .wr_en_i(wr_en_s[3]), .wr_addr_i(wr_addr_s[3]), .wr_data_i(wr_data_s[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference memory: 1024 words at byte address 0.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en_s[i] && (wr_addr_s[i] < 32'h1000)) begin
                mdl[i][wr_addr_s[i][11:2]] <= wr_data_s[i];
            end
        end
    end

    // Scoreboard: check grant, compare responses, record new grants, and fix
    // the expected data of any entry whose read samples on the coming edge.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            bit   due_now;
            logic exp_gnt;
            due_now = (sb[i].size() > 0) && (sb[i][0].due == cyc);
            exp_gnt = req_s[i] & ~stall_s[i] & ~rst_s[i]
                    & ((sb[i].size() - (due_now ? 1 : 0)) < MAXO[i]);
            check($sformatf("gnt[%0d]@%0d", i, cyc), 32'(gnt_w[i]), 32'(exp_gnt));
            if (rvalid_w[i]) begin
                if (!due_now) begin
                    check($sformatf("unexpected_rvalid[%0d]@%0d", i, cyc), 32'(rvalid_w[i]), 32'd0);
                end else begin
                    e = sb[i].pop_front();
                    check($sformatf("sb_rdata[%0d]@%0d", i, cyc), rdata_w[i], e.data);
                    check($sformatf("sb_err[%0d]@%0d", i, cyc), 32'(err_w[i]), 32'(e.err));
                end
            end else if (due_now) begin
                check($sformatf("missing_rvalid[%0d]@%0d", i, cyc), 32'(rvalid_w[i]), 32'd1);
                void'(sb[i].pop_front());
            end
            if (rst_s[i]) sb[i].delete();
            if (req_s[i] && gnt_w[i]) begin
                e.data = 'x;
                e.err  = !(addr_s[i] < 32'h1000);
                e.idx  = addr_s[i][11:2];
                e.due  = cyc + LAT[i];
                sb[i].push_back(e);
            end
            for (int k = 0; k < sb[i].size(); k++) begin
                if (sb[i][k].due == cyc + 1) begin
                    e      = sb[i][k];
                    e.data = e.err ? 32'h0 : mdl[i][e.idx];
                    sb[i][k] = e;
                end
            end
        end
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < 4; i++) begin
            wr_en_s[i] = 1'b1; wr_addr_s[i] = a; wr_data_s[i] = d;
        end
        tick();
        for (int i = 0; i < 4; i++) wr_en_s[i] = 1'b0;
    endtask

    task automatic fetch(input int i, input logic [31:0] a);
        bit granted = 1'b0;
        req_s[i]  = 1'b1;
        addr_s[i] = a;
        for (int k = 0; k < 20 && !granted; k++) begin
            @(negedge clk);
            granted = gnt_w[i];
            tick();
        end
        req_s[i] = 1'b0;
        if (!granted) check($sformatf("fetch_timeout[%0d]", i), 32'(granted), 32'd1);
    endtask

    task automatic expect_resp(input int i, input string tag, input logic [31:0] d, input logic e);
        bit found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (rvalid_w[i]) begin
                found = 1'b1;
                check({tag, "_rdata"}, rdata_w[i], d);
                check({tag, "_err"}, 32'(err_w[i]), 32'(e));
            end
            tick();
        end
        if (!found) check({tag, "_timeout"}, 32'(found), 32'd1);
    endtask

    task automatic drain();
        int pending;
        for (int k = 0; k < 50; k++) begin
            pending = 0;
            for (int i = 0; i < 4; i++) pending += sb[i].size();
            if (pending == 0) break;
            tick();
        end
        pending = 0;
        for (int i = 0; i < 4; i++) pending += sb[i].size();
        if (pending != 0) check("drain_timeout", 32'(pending), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst_s[i] = 1'b1; req_s[i] = 1'b0; addr_s[i] = '0; stall_s[i] = 1'b0;
            wr_en_s[i] = 1'b0; wr_addr_s[i] = '0; wr_data_s[i] = '0;
        end
        repeat (2) tick();

        // Reset state
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_rvalid[%0d]", i), 32'(rvalid_w[i]), 32'd0);
            check($sformatf("rst_rdata[%0d]", i), rdata_w[i], 32'd0);
            check($sformatf("rst_err[%0d]", i), 32'(err_w[i]), 32'd0);
        end
        check("rst_cnt_d", 32'(dut_d.cnt_q), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) rst_s[i] = 1'b0;

        preload(32'h0000_0000, 32'h0000_0013);
        preload(32'h0000_0004, 32'h1111_1111);
        preload(32'h0000_0008, 32'h2222_2222);
        preload(32'h0000_000C, 32'h3333_3333);
        preload(32'h0000_0FFC, 32'hDEAD_BEEF);

        // Single fetch, Latency 1
        req_s[0] = 1'b1; addr_s[0] = 32'h0;
        @(negedge clk); check("single_gnt", 32'(gnt_w[0]), 32'd1);
        tick(); req_s[0] = 1'b0;
        @(negedge clk);
        check("single_rvalid", 32'(rvalid_w[0]), 32'd1);
        check("single_rdata", rdata_w[0], 32'h0000_0013);
        check("single_err", 32'(err_w[0]), 32'd0);
        tick();
        @(negedge clk); check("single_rvalid_drop", 32'(rvalid_w[0]), 32'd0);
        tick();

        // Back-to-back, Latency 2 / MaxOutstanding 2
        req_s[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            addr_s[1] = 32'(4 * k);
            @(negedge clk);
            check($sformatf("b2b_gnt%0d", k), 32'(gnt_w[1]), 32'd1);
            check($sformatf("b2b_cnt%0d", k), 32'(dut_b.cnt_q <= 2'd2), 32'd1);
            tick();
        end
        req_s[1] = 1'b0;
        drain();

        // Write lands while the read is in flight but before it samples
        req_s[1] = 1'b1; addr_s[1] = 32'h4;
        wr_en_s[1] = 1'b1; wr_addr_s[1] = 32'h4; wr_data_s[1] = 32'h5555_5555;
        @(negedge clk); check("inflight_gnt", 32'(gnt_w[1]), 32'd1);
        tick(); req_s[1] = 1'b0; wr_en_s[1] = 1'b0;
        expect_resp(1, "inflight_new", 32'h5555_5555, 1'b0);
        drain();

        // Outstanding limit, Latency 3 / MaxOutstanding 1
        req_s[2] = 1'b1; addr_s[2] = 32'h0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k % 3 == 0) begin
                check($sformatf("limit_gnt%0d", k), 32'(gnt_w[2]), 32'd1);
                if (k > 0) check($sformatf("limit_rvalid%0d", k), 32'(rvalid_w[2]), 32'd1);
            end else begin
                check($sformatf("limit_nognt%0d", k), 32'(gnt_w[2]), 32'd0);
            end
            check($sformatf("limit_cnt%0d", k), 32'(dut_c.cnt_q <= 1'b1), 32'd1);
            tick();
        end
        req_s[2] = 1'b0;
        drain();

        // Out-of-range fetches, then the last in-range word
        fetch(0, 32'h0000_1000);
        expect_resp(0, "err_1000", 32'h0, 1'b1);
        fetch(0, 32'hFFFF_FFFC);
        expect_resp(0, "err_fffffffc", 32'h0, 1'b1);
        @(negedge clk);
        check("hold_rvalid", 32'(rvalid_w[0]), 32'd0);
        check("hold_rdata", rdata_w[0], 32'h0);
        check("hold_err", 32'(err_w[0]), 32'd1);
        tick();
        fetch(0, 32'h0000_0FFC);
        expect_resp(0, "last_word", 32'hDEAD_BEEF, 1'b0);
        drain();

        // Stall for five cycles, then grant with a same-cycle write collision
        stall_s[0] = 1'b1; req_s[0] = 1'b1; addr_s[0] = 32'h8;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); check($sformatf("stall_gnt%0d", k), 32'(gnt_w[0]), 32'd0);
            tick();
        end
        stall_s[0] = 1'b0;
        wr_en_s[0] = 1'b1; wr_addr_s[0] = 32'h8; wr_data_s[0] = 32'hAAAA_AAAA;
        @(negedge clk); check("unstall_gnt", 32'(gnt_w[0]), 32'd1);
        tick(); req_s[0] = 1'b0; wr_en_s[0] = 1'b0;
        @(negedge clk);
        check("collision_rvalid", 32'(rvalid_w[0]), 32'd1);
        check("collision_old", rdata_w[0], 32'h2222_2222);
        tick();
        fetch(0, 32'h8);
        expect_resp(0, "collision_new", 32'hAAAA_AAAA, 1'b0);
        drain();

        // Reset with two requests in flight, Latency 3
        req_s[3] = 1'b1; addr_s[3] = 32'h0;
        @(negedge clk); check("rst_mid_gnt0", 32'(gnt_w[3]), 32'd1);
        tick(); addr_s[3] = 32'h4;
        @(negedge clk); check("rst_mid_gnt1", 32'(gnt_w[3]), 32'd1);
        tick(); req_s[3] = 1'b0; rst_s[3] = 1'b1;
        tick(); rst_s[3] = 1'b0;
        @(negedge clk);
        check("rst_mid_cnt", 32'(dut_d.cnt_q), 32'd0);
        check("rst_mid_rdata", rdata_w[3], 32'h0);
        check("rst_mid_err", 32'(err_w[3]), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); check($sformatf("rst_mid_quiet%0d", k), 32'(rvalid_w[3]), 32'd0);
            tick();
        end
        fetch(3, 32'h4);
        expect_resp(3, "after_rst", 32'h1111_1111, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_instr_mem_responder
